// File: rtl/enc_bundler_accum.sv
// Per-dimension popcount accumulator over the beats of one sample; thresholds the counts
// into a bundled sparse hypervector and holds it until the similarity stage takes it.
module enc_bundler_accum #(
  parameter int HV_DIM    = 1024,
  parameter int NUM_IN    = 10,
  parameter int MAX_BEATS = 8,
  parameter int THRESHOLD = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [NUM_IN*HV_DIM-1:0] shifted_hv,
  output logic                     in_ready,
  output logic [HV_DIM-1:0]        bundled_hv,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     beat_ovf,
  output logic [1:0]               state_dbg
);

  localparam int CNT_W = $clog2(NUM_IN*MAX_BEATS+1);
  localparam int BC_W  = $clog2(MAX_BEATS+2);
  localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [BC_W-1:0]  BC_LIMIT = BC_W'(MAX_BEATS);
  localparam logic [BC_W-1:0]  BC_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] count_q    [HV_DIM];
  logic [CNT_W-1:0] count_next [HV_DIM];
  logic [CNT_W-1:0] inc        [HV_DIM];
  logic [CNT_W:0]   sum        [HV_DIM];
  logic [HV_DIM-1:0] thr_hv;
  logic [BC_W-1:0]   beat_cnt_q;
  logic              sat_any;
  logic              accept;
  logic              beat_over;

  // Handshakes: a beat transfers on a rising edge where in_valid & in_ready; the bundled HV
  // transfers where out_valid & out_ready. Neither valid may drop or change payload until it transfers.
  assign in_ready  = (state_q != DONE);
  assign accept    = in_valid & in_ready;
  assign state_dbg = state_q;
  assign beat_over = (state_q == ACCUM) && (beat_cnt_q >= BC_LIMIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_last ? DONE : ACCUM;
      ACCUM:   if (accept && in_last) state_d = DONE;
      DONE:    if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The first beat of a sample overwrites the counts, so no clear cycle is needed.
  always_comb begin
    sat_any = 1'b0;
    for (int d = 0; d < HV_DIM; d++) begin
      inc[d] = '0;
      for (int i = 0; i < NUM_IN; i++) begin
        inc[d] = inc[d] + CNT_W'(shifted_hv[i*HV_DIM + d]);
      end
      sum[d] = {1'b0, count_q[d]} + {1'b0, inc[d]};
      if (state_q == IDLE) begin
        count_next[d] = inc[d];
      end else if (sum[d][CNT_W]) begin
        count_next[d] = CNT_MAX;
        sat_any       = 1'b1;
      end else begin
        count_next[d] = sum[d][CNT_W-1:0];
      end
      thr_hv[d] = (count_next[d] >= THR);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      bundled_hv <= '0;
      out_valid  <= 1'b0;
      beat_ovf   <= 1'b0;
      for (int d = 0; d < HV_DIM; d++) count_q[d] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        for (int d = 0; d < HV_DIM; d++) count_q[d] <= count_next[d];
        if (state_q == IDLE) beat_cnt_q <= BC_W'(1);
        else if (beat_cnt_q != BC_MAX) beat_cnt_q <= beat_cnt_q + BC_W'(1);
        if (sat_any || beat_over) beat_ovf <= 1'b1;
      end
      if (accept && in_last) begin
        bundled_hv <= thr_hv;
        out_valid  <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_enc_bundler_accum.sv
// Directed bench for enc_bundler_accum: hand-computed bundled HVs checked by a handshake
// monitor against an expected queue, plus direct checks of control outputs.
module tb_enc_bundler_accum;

  localparam int HV_DIM    = 1024;
  localparam int NUM_IN    = 10;
  localparam int MAX_BEATS = 8;
  localparam int VW        = NUM_IN*HV_DIM;

  logic              clk = 1'b0;
  logic              nrst;
  logic              in_valid;
  logic              in_last;
  logic [VW-1:0]     shifted_hv;
  logic              in_ready;
  logic [HV_DIM-1:0] bundled_hv;
  logic              out_valid;
  logic              out_ready;
  logic              beat_ovf;
  logic [1:0]        state_dbg;

  logic [HV_DIM-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  enc_bundler_accum #(
    .HV_DIM(HV_DIM), .NUM_IN(NUM_IN), .MAX_BEATS(MAX_BEATS), .THRESHOLD(4)
  ) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_last(in_last),
    .shifted_hv(shifted_hv), .in_ready(in_ready), .bundled_hv(bundled_hv),
    .out_valid(out_valid), .out_ready(out_ready), .beat_ovf(beat_ovf),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_hv(input string tag, input logic [HV_DIM-1:0] obs,
                          input logic [HV_DIM-1:0] exp);
    for (int c = 0; c < HV_DIM/64; c++)
      check($sformatf("%s_w%0d", tag, c), obs[c*64 +: 64], exp[c*64 +: 64]);
  endtask

  function automatic logic [HV_DIM-1:0] bitv(input int b);
    logic [HV_DIM-1:0] m;
    m = '0;
    m[b] = 1'b1;
    return m;
  endfunction

  // mask m replicated into HVs 0..n-1
  function automatic logic [VW-1:0] rep(input logic [HV_DIM-1:0] m, input int n);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*HV_DIM +: HV_DIM] = m;
    return v;
  endfunction

  function automatic logic [VW-1:0] one_hv(input logic [HV_DIM-1:0] m, input int idx);
    logic [VW-1:0] v;
    v = '0;
    v[idx*HV_DIM +: HV_DIM] = m;
    return v;
  endfunction

  // driver: called 2 time units after a rising edge, returns likewise after acceptance
  task automatic beat(input logic [VW-1:0] v, input logic last);
    int n;
    in_valid = 1'b1; shifted_hv = v; in_last = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("beat_accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #2;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #2;
  endtask

  // scoreboard: every output handshake must match the head of exp_q
  always @(negedge clk) begin
    if (nrst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 64'd1, 64'd0);
      else check_hv("bundled_hv", bundled_hv, exp_q.pop_front());
    end
  end

  logic [HV_DIM-1:0] ones, zeros, exp_a, exp_b, m;

  initial begin
    ones = '1; zeros = '0;
    nrst = 1'b0; in_valid = 1'b0; in_last = 1'b0; shifted_hv = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_beat_ovf", 64'(beat_ovf), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    check_hv("rst_hv", bundled_hv, zeros);
    @(posedge clk); #2;
    nrst = 1'b1;

    // single beat: bits 0..3 in all HVs, bit 5 in 3 HVs
    @(negedge clk);
    check("t2_pre_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #2;
    m = '0; m[3:0] = 4'hF;
    exp_q.push_back(m);
    beat(rep(m, 10) | rep(bitv(5), 3), 1'b1);
    check("t2_latency_valid", 64'(out_valid), 64'd1);
    drain();

    // bit 7 from one HV per beat: 4 beats reach threshold, 3 do not
    exp_q.push_back(bitv(7));
    for (int b = 0; b < 4; b++) beat(one_hv(bitv(7), b), b == 3);
    drain();
    exp_q.push_back(zeros);
    for (int b = 0; b < 3; b++) beat(one_hv(bitv(7), b + 4), b == 2);
    drain();

    // backpressure with next sample already presented
    m = '0; m[13:10] = 4'hF;
    exp_a = m;
    exp_b = bitv(20);
    exp_q.push_back(exp_a);
    exp_q.push_back(exp_b);
    out_ready = 1'b0;
    in_valid = 1'b1; in_last = 1'b1; shifted_hv = rep(exp_a, 10);
    @(posedge clk); #2;
    shifted_hv = rep(exp_b, 10);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t4_hold_valid", 64'(out_valid), 64'd1);
      check("t4_hold_in_ready", 64'(in_ready), 64'd0);
      check("t4_hold_state", 64'(state_dbg), 64'd2);
      check_hv("t4_hold_hv", bundled_hv, exp_a);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t4_post_hs_valid", 64'(out_valid), 64'd0);
    check("t4_post_hs_in_ready", 64'(in_ready), 64'd1);
    check_hv("t4_post_hs_hv_kept", bundled_hv, exp_a);
    @(posedge clk); #2;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("t4_b_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #2;
    drain();

    // in_last without in_valid is ignored
    in_last = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_stray_last_valid", 64'(out_valid), 64'd0);
    check("t5_stray_last_state", 64'(state_dbg), 64'd0);
    @(posedge clk); #2;
    in_last = 1'b0;

    // back-to-back samples: all ones then all zeros
    exp_q.push_back(ones);
    exp_q.push_back(zeros);
    beat(rep(ones, 10), 1'b1);
    beat(rep(zeros, 10), 1'b1);
    drain();
    check("t5_ovf_clear", 64'(beat_ovf), 64'd0);

    // reset in the middle of a sample
    beat(rep(bitv(30), 10), 1'b0);
    beat(rep(bitv(30), 10), 1'b0);
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1_out_valid", 64'(out_valid), 64'd0);
    check("t1_in_ready", 64'(in_ready), 64'd1);
    check_hv("t1_hv", bundled_hv, zeros);
    @(posedge clk); #2;
    nrst = 1'b1;
    exp_q.push_back(bitv(31));
    beat(rep(bitv(31), 10) | rep(bitv(30), 2), 1'b1);
    drain();

    // beat overflow: 9 non-last beats, then a last beat
    exp_q.push_back(ones);
    for (int b = 0; b < MAX_BEATS; b++) beat(rep(ones, 10), 1'b0);
    check("t6_ovf_at_max", 64'(beat_ovf), 64'd0);
    beat(rep(ones, 10), 1'b0);
    check("t6_ovf_over_max", 64'(beat_ovf), 64'd1);
    beat(rep(ones, 10), 1'b1);
    drain();
    exp_q.push_back(zeros);
    beat(rep(zeros, 10), 1'b1);
    drain();
    check("t6_ovf_sticky", 64'(beat_ovf), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
